// File: rtl/upsample_ctrl.sv
// upsample_ctrl: 2x nearest-neighbour upsampler in front of a feature buffer.
// Each input pixel is fetched once per output row and emitted twice; each
// input row is fetched and emitted twice (once per vertical repeat).
// Optional feature: define UPSAMPLE_ZP_EN to requantise every byte
// (in - zero_point_in + zero_point_out, saturated to int8) at capture.
module upsample_ctrl (
    input  logic        sclk,
    input  logic        s_rst,
    input  logic        upsample_start,
    input  logic [1:0]  site_type,
    input  logic [1:0]  batch_type,
    input  logic [7:0]  zero_point_in,
    input  logic [7:0]  zero_point_out,
    output logic        rd_en,
    output logic [13:0] rd_addr,
    input  logic [63:0] rd_data,
    output logic [63:0] up_data,
    output logic        up_valid,
    input  logic        up_ready,
    output logic        upsample_finish,
    output logic        busy
);

    localparam int unsigned CNT_W   = 6;
    localparam int unsigned ADDR_W  = 14;
    localparam int unsigned PIX_W   = 64;
    localparam int unsigned LANES   = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_EMIT0, S_EMIT1, S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_start_low;
    logic [1:0]          r_site;
    logic [1:0]          r_batch;
    logic [CNT_W-1:0]    r_c;
    logic [CNT_W-1:0]    r_r;
    logic                r_v;
    logic [1:0]          r_b;
    logic [PIX_W-1:0]    r_hold;
    logic [PIX_W-1:0]    w_proc;
    logic                w_accept;
    logic                w_adv;
    logic [CNT_W-1:0]    w_dim_max;
    logic                w_last_col;
    logic                w_last_row;
    logic                w_last_pix;
    logic [3:0]          w_bshift;
    logic [3:0]          w_rshift;

    // r_start_low is cleared by reset, so a level held high through reset
    // looks like "previously high" and cannot retrigger a run.
    assign w_accept   = upsample_start & r_start_low & (r_state == S_IDLE);
    assign w_adv      = (r_state == S_EMIT1) & up_ready;
    assign w_dim_max  = CNT_W'((7'd8 << r_site) - 7'd1);
    assign w_last_col = (r_c == w_dim_max);
    assign w_last_row = (r_r == w_dim_max);
    assign w_last_pix = w_last_col & r_v & w_last_row & (r_b == r_batch);
    assign w_bshift   = 4'd6 + {1'b0, r_site, 1'b0};
    assign w_rshift   = 4'd3 + {2'b00, r_site};
    assign rd_addr    = (ADDR_W'(r_b) << w_bshift) | (ADDR_W'(r_r) << w_rshift) | ADDR_W'(r_c);
    assign up_data    = r_hold;

    // State register
    always_ff @(posedge sclk) begin
        if (s_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_FETCH;
            S_FETCH: w_next = S_WAIT;
            S_WAIT:  w_next = S_EMIT0;
            S_EMIT0: if (up_ready) w_next = S_EMIT1;
            S_EMIT1: if (up_ready) w_next = w_last_pix ? S_DONE : S_FETCH;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        rd_en           = 1'b0;
        up_valid        = 1'b0;
        upsample_finish = 1'b0;
        busy            = 1'b0;
        case (r_state)
            S_FETCH: begin rd_en = 1'b1; busy = 1'b1; end
            S_WAIT:  busy = 1'b1;
            S_EMIT0, S_EMIT1: begin up_valid = 1'b1; busy = 1'b1; end
            S_DONE:  begin upsample_finish = 1'b1; busy = 1'b1; end
            default: ;
        endcase
    end

    // Start edge detector
    always_ff @(posedge sclk) begin
        if (s_rst) r_start_low <= 1'b0;
        else       r_start_low <= ~upsample_start;
    end

    // Config latch and scan counters (column inner, repeat, row, batch outer)
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            r_site  <= '0;
            r_batch <= '0;
            r_c     <= '0;
            r_r     <= '0;
            r_v     <= 1'b0;
            r_b     <= '0;
        end else if (w_accept) begin
            r_site  <= site_type;
            r_batch <= batch_type;
            r_c     <= '0;
            r_r     <= '0;
            r_v     <= 1'b0;
            r_b     <= '0;
        end else if (w_adv && !w_last_pix) begin
            if (!w_last_col) begin
                r_c <= r_c + CNT_W'(1);
            end else begin
                r_c <= '0;
                r_v <= ~r_v;
                if (r_v) begin
                    if (!w_last_row) begin
                        r_r <= r_r + CNT_W'(1);
                    end else begin
                        r_r <= '0;
                        r_b <= r_b + 2'd1;
                    end
                end
            end
        end
    end

`ifdef UPSAMPLE_ZP_EN
    logic [7:0]         r_zpi;
    logic [7:0]         r_zpo;
    logic signed [9:0]  w_sum;

    // Zero points latched alongside the geometry
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            r_zpi <= '0;
            r_zpo <= '0;
        end else if (w_accept) begin
            r_zpi <= zero_point_in;
            r_zpo <= zero_point_out;
        end
    end

    // Per-lane requantise with int8 saturation
    always_comb begin
        w_proc = '0;
        w_sum  = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum = $signed({{2{rd_data[8*i+7]}}, rd_data[8*i +: 8]})
                  - $signed({{2{r_zpi[7]}}, r_zpi})
                  + $signed({{2{r_zpo[7]}}, r_zpo});
            if (w_sum > 10'sd127)       w_proc[8*i +: 8] = 8'h7F;
            else if (w_sum < -10'sd128) w_proc[8*i +: 8] = 8'h80;
            else                        w_proc[8*i +: 8] = w_sum[7:0];
        end
    end
`else
    logic w_unused_zp;

    // Pass-through; zero point ports are intentionally ignored
    always_comb begin
        w_proc      = rd_data;
        w_unused_zp = ^{zero_point_in, zero_point_out, LANES[0]};
    end
`endif

    // Hold register loaded the cycle read data returns
    always_ff @(posedge sclk) begin
        if (s_rst)                  r_hold <= '0;
        else if (r_state == S_WAIT) r_hold <= w_proc;
    end

endmodule

// File: tb/tb_upsample_ctrl.sv
// Scoreboard bench for upsample_ctrl: expected beats are generated from the
// scan order with nested loops and checked by an independent monitor.
module tb_upsample_ctrl;

    logic        sclk = 1'b0;
    logic        s_rst = 1'b1;
    logic        upsample_start = 1'b0;
    logic [1:0]  site_type = '0;
    logic [1:0]  batch_type = '0;
    logic [7:0]  zero_point_in = '0;
    logic [7:0]  zero_point_out = '0;
    logic        rd_en;
    logic [13:0] rd_addr;
    logic [63:0] rd_data = '0;
    logic [63:0] up_data;
    logic        up_valid;
    logic        up_ready = 1'b1;
    logic        upsample_finish;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int beat_cnt = 0;
    int fin_cnt = 0;
    int overlap_cnt = 0;
    bit rdy_rand = 1'b0;
    bit held_v = 1'b0;
    logic [63:0] held;
    logic [63:0] salt = '0;
    logic signed [7:0] m_zpi = '0;
    logic signed [7:0] m_zpo = '0;
    logic [63:0] exp_q[$];

    upsample_ctrl dut (
        .sclk(sclk), .s_rst(s_rst), .upsample_start(upsample_start),
        .site_type(site_type), .batch_type(batch_type),
        .zero_point_in(zero_point_in), .zero_point_out(zero_point_out),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
        .upsample_finish(upsample_finish), .busy(busy)
    );

    always #5 sclk = ~sclk;

    function automatic logic [63:0] pat(int a);
        logic [13:0] a14;
        a14 = 14'(a);
        return {4{2'b00, a14}} ^ salt;
    endfunction

    function automatic logic [7:0] zp_byte(logic [7:0] b);
`ifdef UPSAMPLE_ZP_EN
        int x;
        x = int'($signed(b)) - int'(m_zpi) + int'(m_zpo);
        if (x > 127)  x = 127;
        if (x < -128) x = -128;
        return 8'(x);
`else
        return b;
`endif
    endfunction

    function automatic logic [63:0] model_pix(int a);
        logic [63:0] p;
        logic [63:0] o;
        p = pat(a);
        o = '0;
        for (int i = 0; i < 8; i++) o[8*i +: 8] = zp_byte(p[8*i +: 8]);
        return o;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Output order: batch, input row, vertical repeat, column, horizontal repeat
    task automatic build_expected(int st, int bt);
        int w;
        w = 8 << st;
        for (int b = 0; b <= bt; b++)
            for (int r = 0; r < w; r++)
                for (int v = 0; v < 2; v++)
                    for (int c = 0; c < w; c++)
                        repeat (2) exp_q.push_back(model_pix(b*w*w + r*w + c));
    endtask

    // Feature buffer: one-cycle read latency
    always @(posedge sclk) begin
        if (rd_en) rd_data <= pat(int'(rd_addr));
    end

    // Downstream ready: always high or coin toss per cycle
    always @(posedge sclk) begin
        #1;
        up_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops and compares on each handshake, checks stall stability
    always @(negedge sclk) begin
        if (!s_rst) begin
            if (rd_en && up_valid) overlap_cnt++;
            if (upsample_finish) fin_cnt++;
            if (up_valid) begin
                if (held_v) check("stall_stable", up_data, held);
                if (up_ready) begin
                    beat_cnt++;
                    held_v = 1'b0;
                    check("busy_on_beat", 64'(busy), 64'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual=%h expected=none", up_data);
                    end else begin
                        check("beat_data", up_data, exp_q.pop_front());
                    end
                end else begin
                    held   = up_data;
                    held_v = 1'b1;
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    task automatic check_idle_outputs(string tag);
        check({tag, "_rd_en"}, 64'(rd_en), 64'd0);
        check({tag, "_up_valid"}, 64'(up_valid), 64'd0);
        check({tag, "_finish"}, 64'(upsample_finish), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        check({tag, "_up_data"}, up_data, 64'd0);
    endtask

    // Starts a run, perturbs config after accept, waits for the finish pulse
    task automatic run(int st, int bt, logic [7:0] zpi, logic [7:0] zpo, bit rr, bit second_edge);
        int total;
        int b0;
        int f0;
        int budget;
        bit done;
        total    = 4 * (8 << st) * (8 << st) * (bt + 1);
        salt     = {$urandom, $urandom};
        m_zpi    = zpi;
        m_zpo    = zpo;
        rdy_rand = rr;
        @(posedge sclk); #1;
        site_type      = 2'(st);
        batch_type     = 2'(bt);
        zero_point_in  = zpi;
        zero_point_out = zpo;
        build_expected(st, bt);
        b0 = beat_cnt;
        f0 = fin_cnt;
        upsample_start = 1'b1;
        @(posedge sclk); #1;
        site_type      = 2'($urandom);
        batch_type     = 2'($urandom);
        zero_point_in  = 8'($urandom);
        zero_point_out = 8'($urandom);
        check("busy_after_start", 64'(busy), 64'd1);
        repeat (3) @(posedge sclk);
        #1 upsample_start = 1'b0;
        if (second_edge) begin
            repeat (20) @(posedge sclk);
            #1 upsample_start = 1'b1;
            repeat (5) @(posedge sclk);
            #1 upsample_start = 1'b0;
        end
        budget = total * 8 + 200;
        done   = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge sclk);
            if (fin_cnt != f0) done = 1'b1;
        end
        check("finish_seen", 64'(done), 64'd1);
        repeat (4) @(posedge sclk);
        #1;
        check("finish_pulses", 64'(fin_cnt - f0), 64'd1);
        check("beat_count", 64'(beat_cnt - b0), 64'(total));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
        exp_q.delete();
        rdy_rand = 1'b0;
    endtask

    // Reset mid-run with start held high: run abandoned, no retrigger
    task automatic reset_mid_run();
        int b0;
        int f0;
        bit reached;
        salt  = {$urandom, $urandom};
        m_zpi = '0;
        m_zpo = '0;
        @(posedge sclk); #1;
        site_type  = 2'd0;
        batch_type = 2'd0;
        build_expected(0, 0);
        b0 = beat_cnt;
        upsample_start = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            @(posedge sclk);
            if (beat_cnt - b0 >= 100) reached = 1'b1;
        end
        check("reached_100_beats", 64'(reached), 64'd1);
        #1 s_rst = 1'b1;
        exp_q.delete();
        @(posedge sclk); #1;
        check_idle_outputs("in_reset");
        s_rst = 1'b0;
        b0 = beat_cnt;
        f0 = fin_cnt;
        repeat (30) @(posedge sclk);
        #1;
        check("no_restart_busy", 64'(busy), 64'd0);
        check("no_restart_beats", 64'(beat_cnt - b0), 64'd0);
        check("no_finish_after_reset", 64'(fin_cnt - f0), 64'd0);
        upsample_start = 1'b0;
        repeat (2) @(posedge sclk);
    endtask

    initial begin
        repeat (3) @(posedge sclk);
        #1;
        check_idle_outputs("reset");
        s_rst = 1'b0;
        repeat (3) @(posedge sclk);

        run(0, 0, 8'd0, 8'd0, 1'b0, 1'b0);
        run(0, 0, 8'd0, 8'd0, 1'b1, 1'b0);
        run(1, 1, 8'($urandom), 8'($urandom), 1'b1, 1'b1);
        run(0, 3, 8'd10, 8'hFB, 1'b1, 1'b0);
        reset_mid_run();
        run(0, 0, 8'd10, 8'hFB, 1'b0, 1'b0);
        run(1, 3, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
        run(3, 0, 8'd0, 8'd0, 1'b0, 1'b0);

        check("rd_en_up_valid_overlap", 64'(overlap_cnt), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
